// File: rtl/net_iface_tx_pkg.sv
// Shared definitions for the router network interface: packet width and the
// transmit handshake state encoding.
package net_iface_tx_pkg;

  localparam int unsigned PKT_WIDTH = 11;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSetup = 2'd1,
    StReqHi = 2'd2,
    StReqLo = 2'd3
  } tx_state_e;

endpackage

// File: rtl/net_iface_tx_sync_fifo.sv
// Single-clock FIFO with first-word fall-through read and a registered
// not-full flag; shared by the transmit and receive network interfaces.
module sync_fifo
  import net_iface_tx_pkg::*;
#(
  parameter int unsigned WIDTH = PKT_WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             wr_ready_q;
  logic             wr_fire, rd_fire;
  logic             full_d;

  assign empty    = (wptr_q == rptr_q);
  assign wr_ready = wr_ready_q;
  assign wr_fire  = wr_valid & wr_ready_q;
  assign rd_fire  = rd_en & ~empty;
  assign rd_data  = mem[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q + {{AW{1'b0}}, wr_fire};
    rptr_d = rptr_q + {{AW{1'b0}}, rd_fire};
    // Full when the wrap bits differ and the index bits match.
    full_d = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      wr_ready_q <= 1'b1;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      wr_ready_q <= ~full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/net_iface_tx.sv
// Transmit side of the router network interface: queues packets and sends
// them over a bundled-data 4-phase req/ack channel with a synchronized ack.
module net_iface_tx
  import net_iface_tx_pkg::*;
#(
  parameter int unsigned WIDTH       = PKT_WIDTH,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  output logic             ch_req,
  output logic [WIDTH-1:0] ch_data,
  input  logic             ch_ack,
  output logic [7:0]       sent_cnt,
  output logic             busy
);

  tx_state_e              state_q;
  logic                   ch_req_q;
  logic [WIDTH-1:0]       ch_data_q;
  logic [7:0]             sent_cnt_q;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_s;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic [WIDTH-1:0]       fifo_head;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_en    (fifo_pop),
    .rd_data  (fifo_head),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q[0] <= ch_ack;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        ack_sync_q[i] <= ack_sync_q[i-1];
      end
    end
  end

  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  // A stale ack held high keeps the channel parked in idle.
  assign fifo_pop = (state_q == StIdle) && !fifo_empty && !ack_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ch_req_q   <= 1'b0;
      ch_data_q  <= '0;
      sent_cnt_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (fifo_pop) begin
            ch_data_q <= fifo_head;
            state_q   <= StSetup;
          end
        end
        StSetup: begin
          // Data has been stable for a full cycle before req rises.
          ch_req_q <= 1'b1;
          state_q  <= StReqHi;
        end
        StReqHi: begin
          if (ack_s) begin
            ch_req_q <= 1'b0;
            state_q  <= StReqLo;
          end
        end
        StReqLo: begin
          if (!ack_s) begin
            sent_cnt_q <= sent_cnt_q + 8'd1;
            state_q    <= StIdle;
          end
        end
        default: begin
          ch_req_q <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

  assign ch_req   = ch_req_q;
  assign ch_data  = ch_data_q;
  assign sent_cnt = sent_cnt_q;
  assign busy     = !fifo_empty || (state_q != StIdle);

endmodule

// File: tb/tb_net_iface_tx.sv
// Directed bench for net_iface_tx with a 4-phase router model and a
// packet sink that records every request in arrival order.
module tb_net_iface_tx;
  import net_iface_tx_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 wr_valid = 1'b0;
  logic [PKT_WIDTH-1:0] wr_data = '0;
  logic                 wr_ready;
  logic                 ch_req;
  logic [PKT_WIDTH-1:0] ch_data;
  logic                 ch_ack;
  logic [7:0]           sent_cnt;
  logic                 busy;

  logic                 manual_mode = 1'b1;
  logic                 manual_ack = 1'b0;
  logic                 model_ack = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  logic [PKT_WIDTH-1:0] rx_q[$];
  logic [PKT_WIDTH-1:0] held = '0;
  logic                 req_seen = 1'b0;
  int                   unstable = 0;

  assign ch_ack = manual_mode ? manual_ack : model_ack;

  net_iface_tx #(
    .WIDTH       (PKT_WIDTH),
    .DEPTH       (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .ch_req   (ch_req),
    .ch_data  (ch_data),
    .ch_ack   (ch_ack),
    .sent_cnt (sent_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Router model: acknowledges 3 ns after each req edge.
  always begin
    @(posedge ch_req);
    #3 model_ack = 1'b1;
    @(negedge ch_req);
    #3 model_ack = 1'b0;
  end

  // Sink: logs data at each req rise and flags data changes while req is high.
  always @(negedge clk) begin
    if (ch_req === 1'b1) begin
      if (!req_seen) begin
        rx_q.push_back(ch_data);
        held <= ch_data;
      end else if (ch_data !== held) begin
        unstable <= unstable + 1;
      end
    end
    req_seen <= (ch_req === 1'b1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [PKT_WIDTH-1:0] d);
    int n = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    while (!wr_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("push_timeout", 32'(n), 32'd0);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_sent(input logic [7:0] target, input int budget);
    int n = 0;
    while (sent_cnt !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int base;
    int n;
    int mism;
    int hi_cnt;
    logic [PKT_WIDTH-1:0] exp_q[$];
    logic [PKT_WIDTH-1:0] burst[5];
    logic [PKT_WIDTH-1:0] fp[5];

    // Reset values while reset is held.
    #7;
    check("rst_ch_req", 32'(ch_req), 32'd0);
    check("rst_ch_data", 32'(ch_data), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_sent_cnt", 32'(sent_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Single packet.
    manual_mode = 1'b0;
    do_reset();
    base = rx_q.size();
    push(11'b01010101010);
    wait_sent(8'd1, 200);
    repeat (3) @(negedge clk);
    check("single_sent_cnt", 32'(sent_cnt), 32'd1);
    check("single_pulses", 32'(rx_q.size() - base), 32'd1);
    check("single_data", 32'(rx_q[base]), 32'h2AA);
    check("single_idle_busy", 32'(busy), 32'd0);

    // Burst against a stalled (held-high) ack.
    burst = '{11'h000, 11'h7FF, 11'h7E0, 11'h01F, 11'h2AA};
    manual_mode = 1'b1;
    manual_ack  = 1'b1;
    do_reset();
    base = rx_q.size();
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) push(burst[i]);
    check("burst_ready_after3", 32'(wr_ready), 32'd1);
    push(burst[3]);
    check("burst_ready_after4", 32'(wr_ready), 32'd0);
    check("burst_req_stalled", 32'(ch_req), 32'd0);
    check("burst_busy", 32'(busy), 32'd1);
    manual_mode = 1'b0;
    push(burst[4]);
    wait_sent(8'd5, 500);
    check("burst_sent_cnt", 32'(sent_cnt), 32'd5);
    check("burst_count", 32'(rx_q.size() - base), 32'd5);
    for (int i = 0; i < 5; i++) check($sformatf("burst_order%0d", i), 32'(rx_q[base+i]),
                                      32'(burst[i]));

    // Full FIFO with a write pending in the cycle of the pop.
    fp = '{11'h123, 11'h456, 11'h789, 11'h0AB, 11'h5CD};
    manual_mode = 1'b1;
    manual_ack  = 1'b1;
    do_reset();
    base = rx_q.size();
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) push(fp[i]);
    check("fullpop_full", 32'(wr_ready), 32'd0);
    wr_valid   = 1'b1;
    wr_data    = fp[4];
    manual_ack = 1'b0;
    n = 0;
    while (ch_data !== fp[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("fullpop_popped", 32'(ch_data), 32'(fp[0]));
    check("fullpop_refused", 32'(wr_ready), 32'd1);
    @(negedge clk);
    check("fullpop_accept", 32'(wr_ready), 32'd0);
    wr_valid    = 1'b0;
    manual_mode = 1'b0;
    wait_sent(8'd5, 500);
    check("fullpop_sent_cnt", 32'(sent_cnt), 32'd5);
    check("fullpop_count", 32'(rx_q.size() - base), 32'd5);
    mism = 0;
    for (int i = 0; i < 5; i++) if (rx_q[base+i] !== fp[i]) mism++;
    check("fullpop_order", 32'(mism), 32'd0);

    // Reset while in REQ_HI with packets queued.
    manual_mode = 1'b1;
    manual_ack  = 1'b0;
    do_reset();
    base = rx_q.size();
    push(11'h3C3);
    push(11'h111);
    push(11'h222);
    n = 0;
    while (ch_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("midrst_req_high", 32'(ch_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_req_async", 32'(ch_req), 32'd0);
    check("midrst_sent_cnt", 32'(sent_cnt), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_wr_ready", 32'(wr_ready), 32'd1);
    @(negedge clk);
    rst_n       = 1'b1;
    manual_mode = 1'b0;
    repeat (60) @(negedge clk);
    check("midrst_no_resend", 32'(rx_q.size() - base), 32'd1);
    check("midrst_cnt_after", 32'(sent_cnt), 32'd0);

    // Stale ack held across reset release.
    manual_mode = 1'b1;
    manual_ack  = 1'b1;
    do_reset();
    base = rx_q.size();
    repeat (3) @(negedge clk);
    push(11'h555);
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ch_req !== 1'b0) hi_cnt++;
    end
    check("stale_req_held_low", 32'(hi_cnt), 32'd0);
    check("stale_busy", 32'(busy), 32'd1);
    manual_ack  = 1'b0;
    manual_mode = 1'b0;
    wait_sent(8'd1, 200);
    check("stale_sent_cnt", 32'(sent_cnt), 32'd1);
    check("stale_data", 32'(rx_q[rx_q.size()-1]), 32'h555);

    // 260 packets: counter wrap and pointer wrap with order preserved.
    do_reset();
    base = rx_q.size();
    exp_q.delete();
    for (int i = 0; i < 260; i++) begin
      exp_q.push_back(PKT_WIDTH'((i * 37 + 5) & 32'h7FF));
      push(exp_q[i]);
    end
    n = 0;
    while ((rx_q.size() - base < 260 || busy) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("wrap_sent_cnt", 32'(sent_cnt), 32'd4);
    check("wrap_count", 32'(rx_q.size() - base), 32'd260);
    mism = 0;
    for (int i = 0; i < 260; i++) begin
      if (base + i >= rx_q.size() || rx_q[base+i] !== exp_q[i]) mism++;
    end
    check("wrap_order", 32'(mism), 32'd0);
    check("data_stable_under_req", 32'(unstable), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/net_iface_tx.md
NET_IFACE_TX -- requirements
Module: net_iface_tx

Interface
REQ-001 Parameter WIDTH, default 11, packet width in bits, matching the router channel width.
REQ-002 Parameter DEPTH, default 4, transmit FIFO entries; must be a power of two, at least 2.
REQ-003 Parameter SYNC_STAGES, default 2, flip-flop stages synchronizing the incoming ack.
REQ-004 clk  input  1  single clock for all state.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 wr_valid  input  1  producer offers a packet this cycle.
REQ-007 wr_data  input  WIDTH  packet offered by the producer.
REQ-008 wr_ready  output  1  FIFO can accept a packet; high when not full.
REQ-009 ch_req  output  1  4-phase request to the router leaf input channel.
REQ-010 ch_data  output  WIDTH  bundled data to the router channel.
REQ-011 ch_ack  input  1  4-phase acknowledge from the router; asynchronous to clk.
REQ-012 sent_cnt  output  8  count of completed channel handshakes.
REQ-013 busy  output  1  high when FIFO is non-empty or state is not IDLE.

Function
REQ-014 Write occurs on a clock edge with wr_valid and wr_ready both high; wr_data is stored in FIFO order.
REQ-015 wr_ready is registered: low exactly when the FIFO holds DEPTH entries, including entries committed in the current cycle.
REQ-016 A write and a pop in the same cycle when full succeed only for the pop; wr_ready stays low that cycle, so no write is lost or duplicated.
REQ-017 ch_ack passes through SYNC_STAGES flops to form ack_s; no logic uses raw ch_ack.
REQ-018 FSM states: IDLE, SETUP, REQ_HI, REQ_LO.
REQ-019 IDLE -> SETUP when the FIFO is non-empty and ack_s is 0; the head entry is popped and loaded into the ch_data register.
REQ-020 SETUP lasts one cycle with ch_req low, so data is stable one full cycle before request (bundling margin); then -> REQ_HI.
REQ-021 REQ_HI: ch_req high; -> REQ_LO when ack_s is 1.
REQ-022 REQ_LO: ch_req low; when ack_s is 0, sent_cnt increments and the state goes -> IDLE.
REQ-023 ch_data holds its value from SETUP through the end of REQ_LO and changes only on the next IDLE->SETUP transition.
REQ-024 ch_req is a direct flop output with no combinational path.
REQ-025 Minimum spacing from one packet's request rise to the next is 4 + 2*SYNC_STAGES cycles with zero-delay ack.
REQ-026 sent_cnt wraps from 255 to 0.
REQ-027 FIFO pointers are log2(DEPTH)+1 bits; full/empty are derived from the MSB-differ/equal comparison, and wrap-around is correct indefinitely.
REQ-028 If ack_s is 1 in IDLE (stale acknowledge), the block stalls in IDLE until ack_s is 0.

Reset
REQ-029 rst_n low asynchronously sets: state IDLE, ch_req 0, ch_data 0, FIFO empty, wr_ready 1 on release, sent_cnt 0, busy 0, synchronizer flops 0.
REQ-030 Reset during REQ_HI or REQ_LO discards the in-flight packet and all queued packets; no resend occurs.
REQ-031 After release, the first handshake begins only once ack_s is 0, per REQ-028.
REQ-032 Reset deassertion is synchronized externally; the block does not contain a reset synchronizer.

Structure
REQ-033 A shared package holds PKT_WIDTH (11) and the FSM state encoding constants; the router and the bench use the same PKT_WIDTH.
REQ-034 The FIFO is one sub-module, sync_fifo (parameters WIDTH, DEPTH), reused by the receive-side interface.
REQ-035 The ack synchronizer is inline in net_iface_tx, not a separate module.

Verification
REQ-036 Single packet: write 11'b01010101010 with the router model acking after 3 ns -> exactly one ch_req pulse with ch_data stable throughout, and sent_cnt=1.
REQ-037 Burst: write 5 packets 11'h000, 11'h7FF, 11'h7E0, 11'h01F, 11'h2AA with DEPTH=4 and a stalled ack -> wr_ready low after 4 writes; all 5 are delivered in order once ack resumes; sent_cnt=5.
REQ-038 Full plus pop: FIFO full, wr_valid held high in the cycle a pop occurs -> no write accepted that cycle; the next cycle accepts it; no loss and no duplicate.
REQ-039 Reset mid-handshake: assert rst_n low while in REQ_HI -> ch_req goes 0 with no clock edge, FIFO is empty, and sent_cnt=0.
REQ-040 Stale ack: ch_ack held at 1 across reset release with one packet queued -> ch_req stays 0 until ch_ack falls, then the handshake completes.
REQ-041 Wrap: 260 packets sent -> sent_cnt=4, FIFO pointers wrap repeatedly, and data order is preserved (checked by a scoreboard feeding a bitbucket-style sink).
